// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and constants for the memory card board
package memory_pkg;

    localparam int         N_CELLS     = 64;
    localparam logic [3:0] CELL_HIDDEN = 4'hC;
    localparam logic [3:0] CELL_CURSOR = 4'hD;
    localparam logic [3:0] SYM_MAX     = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK1 = 3'd1,
        ST_PICK2 = 3'd2,
        ST_SHOW  = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } state_t;

    // Symbols above SYM_MAX would collide with the hidden/cursor display codes.
    function automatic logic [3:0] clamp_sym(input logic [3:0] v);
        return (v > SYM_MAX) ? SYM_MAX : v;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter that pulses done when it reaches zero
module hold_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;
    logic         r_active;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_load_val;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - W'(1);
            end
        end
    end

    assign o_done = r_active && (r_count == '0);

endmodule

// File: rtl/memory_board_ctrl.sv
// rtl/memory_board_ctrl.sv - memory card game FSM producing a per-cell display matrix
module memory_board_ctrl
    import memory_pkg::*;
#(
    parameter int MISMATCH_CYCLES = 25_000_000,
    parameter int MAX_MISSES      = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            btn_up,
    input  logic            btn_down,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_sel,
    input  logic [63:0][3:0] layout,
    output logic [63:0][3:0] matrix,
    output logic            win,
    output logic            lose,
    output logic [5:0]      misses
);

    localparam int            TW    = (MISMATCH_CYCLES > 1) ? $clog2(MISMATCH_CYCLES) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(MISMATCH_CYCLES - 1);
    localparam logic [6:0]    MAXM  = 7'(MAX_MISSES);

    state_t           r_state;
    logic [63:0][3:0] r_sym;
    logic [63:0]      r_revealed;
    logic [63:0]      r_matched;
    logic [5:0]       r_cursor;
    logic [5:0]       r_idx1;
    logic [5:0]       r_idx2;
    logic [6:0]       r_matched_cnt;
    logic [5:0]       r_misses;

    logic             w_cur_hidden;
    logic             w_sym_eq;
    logic [6:0]       w_cnt_next;
    logic             w_move;
    logic [5:0]       w_cursor_nxt;
    logic [2:0]       w_row;
    logic [2:0]       w_col;
    logic             w_timer_load;
    logic             w_timer_done;

    assign w_row        = r_cursor[5:3];
    assign w_col        = r_cursor[2:0];
    assign w_cur_hidden = !r_revealed[r_cursor] && !r_matched[r_cursor];
    assign w_sym_eq     = (r_sym[r_idx1] == r_sym[r_cursor]);
    assign w_cnt_next   = r_matched_cnt + 7'd2;
    assign w_timer_load = !start && (r_state == ST_PICK2) && btn_sel && w_cur_hidden
                          && (r_cursor != r_idx1) && !w_sym_eq;

    // Moves wrap inside the current row or column; sel outranks any direction.
    always_comb begin
        w_move       = 1'b0;
        w_cursor_nxt = r_cursor;
        if (btn_up) begin
            w_move       = 1'b1;
            w_cursor_nxt = {w_row - 3'd1, w_col};
        end else if (btn_down) begin
            w_move       = 1'b1;
            w_cursor_nxt = {w_row + 3'd1, w_col};
        end else if (btn_left) begin
            w_move       = 1'b1;
            w_cursor_nxt = {w_row, w_col - 3'd1};
        end else if (btn_right) begin
            w_move       = 1'b1;
            w_cursor_nxt = {w_row, w_col + 3'd1};
        end
    end

    hold_timer #(.W(TW)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (start),
        .i_load     (w_timer_load),
        .i_load_val (TLOAD),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sym         <= '0;
            r_revealed    <= '0;
            r_matched     <= '0;
            r_cursor      <= '0;
            r_idx1        <= '0;
            r_idx2        <= '0;
            r_matched_cnt <= '0;
            r_misses      <= '0;
        end else if (start) begin
            for (int i = 0; i < N_CELLS; i++) begin
                r_sym[i] <= clamp_sym(layout[i]);
            end
            r_revealed    <= '0;
            r_matched     <= '0;
            r_cursor      <= '0;
            r_idx1        <= '0;
            r_idx2        <= '0;
            r_matched_cnt <= '0;
            r_misses      <= '0;
            r_state       <= ST_PICK1;
        end else begin
            case (r_state)
                ST_PICK1: begin
                    if (btn_sel) begin
                        if (w_cur_hidden) begin
                            r_revealed[r_cursor] <= 1'b1;
                            r_idx1               <= r_cursor;
                            r_state              <= ST_PICK2;
                        end
                    end else if (w_move) begin
                        r_cursor <= w_cursor_nxt;
                    end
                end
                ST_PICK2: begin
                    if (btn_sel) begin
                        if (w_cur_hidden && (r_cursor != r_idx1)) begin
                            r_idx2 <= r_cursor;
                            if (w_sym_eq) begin
                                r_matched[r_idx1]   <= 1'b1;
                                r_matched[r_cursor] <= 1'b1;
                                r_revealed[r_idx1]  <= 1'b0;
                                r_matched_cnt       <= w_cnt_next;
                                r_state <= (w_cnt_next == 7'(N_CELLS)) ? ST_WIN : ST_PICK1;
                            end else begin
                                r_revealed[r_cursor] <= 1'b1;
                                if (r_misses != 6'h3F) begin
                                    r_misses <= r_misses + 6'd1;
                                end
                                r_state <= ST_SHOW;
                            end
                        end
                    end else if (w_move) begin
                        r_cursor <= w_cursor_nxt;
                    end
                end
                ST_SHOW: begin
                    if (w_timer_done) begin
                        r_revealed[r_idx1] <= 1'b0;
                        r_revealed[r_idx2] <= 1'b0;
                        r_state <= ({1'b0, r_misses} >= MAXM) ? ST_LOSE : ST_PICK1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            if (rst || (r_state == ST_IDLE)) begin
                matrix[i] = CELL_HIDDEN;
            end else if ((r_state == ST_WIN) || (r_state == ST_LOSE)) begin
                matrix[i] = r_sym[i];
            end else if (r_revealed[i] || r_matched[i]) begin
                matrix[i] = r_sym[i];
            end else if (r_cursor == 6'(i)) begin
                matrix[i] = CELL_CURSOR;
            end else begin
                matrix[i] = CELL_HIDDEN;
            end
        end
    end

    assign win    = !rst && (r_state == ST_WIN);
    assign lose   = !rst && (r_state == ST_LOSE);
    assign misses = r_misses;

endmodule

// File: tb/tb_memory_board_ctrl.sv
// tb/tb_memory_board_ctrl.sv - directed-vector bench for memory_board_ctrl
module tb_memory_board_ctrl;

    localparam int MC = 4;
    localparam int MM = 2;

    localparam logic [5:0] P_START = 6'b100000;
    localparam logic [5:0] P_SEL   = 6'b010000;
    localparam logic [5:0] P_UP    = 6'b001000;
    localparam logic [5:0] P_DOWN  = 6'b000100;
    localparam logic [5:0] P_LEFT  = 6'b000010;
    localparam logic [5:0] P_RIGHT = 6'b000001;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [63:0][3:0] layout;
    logic [63:0][3:0] matrix;
    logic             win, lose;
    logic [5:0]       misses;

    logic [63:0][3:0] all_c;
    logic [63:0][3:0] exp_m;
    logic [63:0][3:0] lay_ref;
    int               n_vec = 0;
    int               n_err = 0;
    int               cur;

    always #5 clk = ~clk;

    memory_board_ctrl #(.MISMATCH_CYCLES(MC), .MAX_MISSES(MM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_sel   (btn_sel),
        .layout    (layout),
        .matrix    (matrix),
        .win       (win),
        .lose      (lose),
        .misses    (misses)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [5:0] v);
        {start, btn_sel, btn_up, btn_down, btn_left, btn_right} = v;
        tick();
        {start, btn_sel, btn_up, btn_down, btn_left, btn_right} = '0;
    endtask

    task automatic goto(input int t);
        while ((cur % 8) != (t % 8)) begin
            pulse(P_RIGHT);
            cur = (cur / 8) * 8 + ((cur % 8) + 1) % 8;
        end
        while ((cur / 8) != (t / 8)) begin
            pulse(P_DOWN);
            cur = (((cur / 8) + 1) % 8) * 8 + (cur % 8);
        end
    endtask

    initial begin
        rst = 1'b1;
        {start, btn_sel, btn_up, btn_down, btn_left, btn_right} = '0;
        for (int i = 0; i < 64; i++) begin
            layout[i] = 4'((i / 2) % 12);
            all_c[i]  = 4'hC;
        end
        lay_ref = layout;
        tick();
        tick();
        check("rst_matrix", matrix, all_c);
        check("rst_win", win, 1'b0);
        check("rst_lose", lose, 1'b0);
        check("rst_misses", misses, 6'd0);

        rst = 1'b0;
        tick();
        pulse(P_RIGHT);
        check("idle_matrix", matrix, all_c);

        pulse(P_START);
        cur = 0;
        exp_m = all_c;
        exp_m[0] = 4'hD;
        check("start_matrix", matrix, exp_m);

        pulse(P_SEL);
        check("sel0_faceup", matrix[0], 4'h0);
        pulse(P_SEL);
        check("resel0_ignored", {matrix[1], matrix[0]}, 8'hC0);
        pulse(P_RIGHT);
        cur = 1;
        check("cursor_at_1", matrix[1], 4'hD);
        pulse(P_SEL | P_LEFT);
        check("pair0_matched", {matrix[1], matrix[0]}, 8'h00);
        check("pair0_misses", misses, 6'd0);
        pulse(P_RIGHT);
        cur = 2;
        check("sel_blocks_left", matrix[2], 4'hD);

        pulse(P_DOWN);
        cur = 10;
        goto(15);
        check("col7_cursor", matrix[15], 4'hD);
        pulse(P_RIGHT);
        cur = 8;
        check("wrap_right", {matrix[15], matrix[8]}, 8'hCD);
        pulse(P_UP);
        cur = 0;
        pulse(P_UP);
        cur = 56;
        check("wrap_up", matrix[56], 4'hD);
        check("pair0_persist", {matrix[1], matrix[0]}, 8'h00);

        pulse(P_START);
        cur = 0;
        pulse(P_SEL);
        goto(2);
        pulse(P_SEL);
        check("show_c1", {matrix[2], matrix[0]}, 8'h10);
        check("show_misses", misses, 6'd1);
        pulse(P_RIGHT);
        check("show_c2", {matrix[2], matrix[0]}, 8'h10);
        pulse(P_SEL);
        check("show_c3", {matrix[2], matrix[0]}, 8'h10);
        tick();
        check("show_c4", {matrix[2], matrix[0]}, 8'h10);
        tick();
        check("show_end", {matrix[3], matrix[2], matrix[0]}, 12'hCDC);
        check("show_no_lose", lose, 1'b0);

        pulse(P_SEL);
        goto(4);
        pulse(P_SEL);
        check("miss2_count", misses, 6'd2);
        tick();
        tick();
        tick();
        check("miss2_still_show", lose, 1'b0);
        tick();
        check("lose_flag", lose, 1'b1);
        check("lose_faceup", matrix, lay_ref);
        pulse(P_RIGHT);
        check("lose_frozen", matrix, lay_ref);
        check("lose_no_win", win, 1'b0);

        pulse(P_START);
        cur = 0;
        check("restart_lose_clr", lose, 1'b0);
        check("restart_misses", misses, 6'd0);
        for (int k = 0; k < 32; k++) begin
            goto(2 * k);
            pulse(P_SEL);
            goto(2 * k + 1);
            if (k == 31) check("win_not_early", win, 1'b0);
            pulse(P_SEL);
        end
        check("win_flag", win, 1'b1);
        check("win_faceup", matrix, lay_ref);
        check("win_misses", misses, 6'd0);

        pulse(P_START);
        cur = 0;
        pulse(P_SEL);
        goto(2);
        pulse(P_SEL);
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_show", matrix, all_c);
        rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        check("idle_after_rst", matrix, all_c);
        check("idle_after_rst_misses", misses, 6'd0);

        layout[0] = 4'hF;
        layout[1] = 4'hC;
        pulse(P_START);
        cur = 0;
        pulse(P_SEL);
        pulse(P_RIGHT);
        pulse(P_SEL);
        check("clamp_sym", {matrix[1], matrix[0]}, 8'hBB);
        check("clamp_misses", misses, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
